// File: rtl/microprogram_io_peripheral.sv
// I/O responder for the microprogrammed CPU's byte-wide IN/OUT ports.
// A host-loaded input FIFO feeds operands to the CPU's IN port. Every change
// seen on the CPU's OUT port is pushed into an output FIFO that the host drains.
// The same change also acknowledges the current operand, so IN advances.
// Ports:
//   clock, reset        - clock; synchronous active-low reset
//   cpu_out / cpu_in    - CPU OUT (captured) / CPU IN (input FIFO head)
//   in_valid            - cpu_in holds a queued operand
//   host_wr_en/_data    - push an operand into the input FIFO
//   host_full           - input FIFO is full
//   host_rd_en          - pop the output FIFO
//   host_rd_data        - output FIFO head (0 when empty)
//   host_empty          - output FIFO is empty
//   out_count           - output FIFO occupancy
//   overflow            - sticky: a CPU result was dropped
module microprogram_io_peripheral #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] cpu_out,
  output logic [DW-1:0] cpu_in,
  output logic          in_valid,
  input  logic          host_wr_en,
  input  logic [DW-1:0] host_wr_data,
  output logic          host_full,
  input  logic          host_rd_en,
  output logic [DW-1:0] host_rd_data,
  output logic          host_empty,
  output logic [AW:0]   out_count,
  output logic          overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] imem [DEPTH];
  logic [DW-1:0] omem [DEPTH];
  logic [AW-1:0] iwr_ptr, ird_ptr, owr_ptr, ord_ptr;
  logic [AW:0]   icount, ocount;
  logic [DW-1:0] last_out;

  logic evt, in_wr, in_pop, out_rd, out_push, out_drop;

  // Change detector and FIFO handshake decisions, all from pre-edge state.
  always_comb begin
    evt      = (cpu_out != last_out);
    in_wr    = host_wr_en && (icount != FULL_CNT);
    in_pop   = evt && (icount != '0);
    out_rd   = host_rd_en && (ocount != '0);
    // A full output FIFO can still accept a push when the host pops the same cycle.
    out_push = evt && ((ocount != FULL_CNT) || out_rd);
    out_drop = evt && !out_push;
  end

  // State update; reset overrides every simultaneous enable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_out <= '0;
      iwr_ptr  <= '0;
      ird_ptr  <= '0;
      icount   <= '0;
      owr_ptr  <= '0;
      ord_ptr  <= '0;
      ocount   <= '0;
      overflow <= 1'b0;
    end else begin
      last_out <= cpu_out;

      if (in_wr) begin
        imem[iwr_ptr] <= host_wr_data;
        iwr_ptr       <= iwr_ptr + AW'(1);
      end
      if (in_pop) begin
        ird_ptr <= ird_ptr + AW'(1);
      end
      if (in_wr && !in_pop) begin
        icount <= icount + (AW+1)'(1);
      end else if (!in_wr && in_pop) begin
        icount <= icount - (AW+1)'(1);
      end

      if (out_push) begin
        omem[owr_ptr] <= cpu_out;
        owr_ptr       <= owr_ptr + AW'(1);
      end
      if (out_rd) begin
        ord_ptr <= ord_ptr + AW'(1);
      end
      if (out_push && !out_rd) begin
        ocount <= ocount + (AW+1)'(1);
      end else if (!out_push && out_rd) begin
        ocount <= ocount - (AW+1)'(1);
      end

      if (out_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Host/CPU-facing views, combinational from state only.
  always_comb begin
    in_valid     = (icount != '0);
    cpu_in       = in_valid ? imem[ird_ptr] : '0;
    host_full    = (icount == FULL_CNT);
    host_empty   = (ocount == '0);
    host_rd_data = host_empty ? '0 : omem[ord_ptr];
    out_count    = ocount;
  end

endmodule

// File: tb/tb_microprogram_io_peripheral.sv
module tb_microprogram_io_peripheral;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cpu_out = 8'h00;
  logic [7:0] cpu_in;
  logic       in_valid;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wr_data = 8'h00;
  logic       host_full;
  logic       host_rd_en = 1'b0;
  logic [7:0] host_rd_data;
  logic       host_empty;
  logic [3:0] out_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  microprogram_io_peripheral #(.DW(8), .DEPTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset), .cpu_out(cpu_out), .cpu_in(cpu_in),
    .in_valid(in_valid), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_full(host_full), .host_rd_en(host_rd_en), .host_rd_data(host_rd_data),
    .host_empty(host_empty), .out_count(out_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: two plain queues plus a sticky flag.
  logic [7:0] iq[$];
  logic [7:0] oq[$];
  bit         m_ovf;
  logic [7:0] m_last;

  always @(posedge clock) begin
    bit ev, wr_ok, pop_ok;
    if (!reset) begin
      iq.delete();
      oq.delete();
      m_ovf  = 1'b0;
      m_last = 8'h00;
    end else begin
      ev     = (cpu_out != m_last);
      wr_ok  = host_wr_en && (iq.size() < DEPTH);
      pop_ok = ev && (iq.size() > 0);
      if (pop_ok) void'(iq.pop_front());
      if (wr_ok) iq.push_back(host_wr_data);
      if (host_rd_en && oq.size() > 0) void'(oq.pop_front());
      if (ev) begin
        if (oq.size() < DEPTH) oq.push_back(cpu_out);
        else m_ovf = 1'b1;
      end
      m_last = cpu_out;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_cpu_in", 32'(cpu_in), (iq.size() != 0) ? 32'(iq[0]) : 32'd0);
      check("m_in_valid", 32'(in_valid), 32'(iq.size() != 0));
      check("m_host_full", 32'(host_full), 32'(iq.size() == DEPTH));
      check("m_rd_data", 32'(host_rd_data), (oq.size() != 0) ? 32'(oq[0]) : 32'd0);
      check("m_host_empty", 32'(host_empty), 32'(oq.size() == 0));
      check("m_out_count", 32'(out_count), 32'(oq.size()));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ops [3];
    logic [7:0] res [3];
    logic [7:0] pp  [8];
    logic [7:0] prev;
    logic [7:0] v;
    ops = '{8'h11, 8'h22, 8'h33};
    res = '{8'h12, 8'h23, 8'h34};
    pp  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hB5};

    // Reset held with activity on every input.
    host_wr_en   = 1'b1;
    host_wr_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      cpu_out = (i % 2 == 0) ? 8'h33 : 8'h44;
      tick();
      chk_en = 1'b1;
    end
    cpu_out    = 8'h00;
    host_wr_en = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_cpu_in", 32'(cpu_in), 32'h0);
    check("rst_in_valid", 32'(in_valid), 32'h0);
    check("rst_host_empty", 32'(host_empty), 32'h1);
    check("rst_out_count", 32'(out_count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_host_full", 32'(host_full), 32'h0);
    tick();
    check("rst_quiet_empty", 32'(host_empty), 32'h1);

    // Operand/result loop: CPU answers operand+1.
    host_wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_wr_data = ops[i];
      tick();
    end
    host_wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("loop_operand", 32'(cpu_in), 32'(ops[i]));
      cpu_out = cpu_in + 8'd1;
      tick();
    end
    check("loop_in_valid_done", 32'(in_valid), 32'h0);
    check("loop_out_count", 32'(out_count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      check("loop_result", 32'(host_rd_data), 32'(res[i]));
      host_rd_en = 1'b1;
      tick();
      host_rd_en = 1'b0;
    end
    check("loop_drained", 32'(host_empty), 32'h1);

    // Input FIFO full: ninth byte is lost.
    host_wr_en = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      host_wr_data = 8'(i);
      tick();
      if (i == 8) check("in_full_at_8", 32'(host_full), 32'h1);
    end
    host_wr_en = 1'b0;
    check("in_full_after_9", 32'(host_full), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("in_order", 32'(cpu_in), 32'(i + 1));
      cpu_out = 8'h50 + 8'(i);
      tick();
    end
    check("in_empty_after", 32'(in_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("in_results", 32'(host_rd_data), 32'h50 + 32'(i));
      host_rd_en = 1'b1;
      tick();
      host_rd_en = 1'b0;
    end

    // Output overflow.
    for (int i = 0; i < 9; i++) begin
      cpu_out = 8'hA0 + 8'(i);
      tick();
    end
    check("ovf_count", 32'(out_count), 32'h8);
    check("ovf_flag", 32'(overflow), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check("ovf_read", 32'(host_rd_data), 32'hA0 + 32'(i));
      host_rd_en = 1'b1;
      tick();
      host_rd_en = 1'b0;
    end
    check("ovf_drained", 32'(host_empty), 32'h1);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Mid-run reset, then full push with concurrent pop.
    cpu_out    = 8'h00;
    host_wr_en = 1'b1;
    reset      = 1'b0;
    tick();
    tick();
    host_wr_en = 1'b0;
    reset      = 1'b1;
    check("rst2_overflow", 32'(overflow), 32'h0);
    check("rst2_in_valid", 32'(in_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cpu_out = 8'hC0 + 8'(i);
      tick();
    end
    check("pp_full", 32'(out_count), 32'h8);
    cpu_out    = 8'hB5;
    host_rd_en = 1'b1;
    tick();
    host_rd_en = 1'b0;
    check("pp_count", 32'(out_count), 32'h8);
    check("pp_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check("pp_read", 32'(host_rd_data), 32'(pp[i]));
      host_rd_en = 1'b1;
      tick();
      host_rd_en = 1'b0;
    end

    // Held value gives a single event; alternating values drain across the wrap.
    cpu_out = 8'h40;
    for (int i = 0; i < 10; i++) tick();
    check("hold_one_event", 32'(out_count), 32'h1);
    prev = 8'h40;
    for (int i = 0; i < 12; i++) begin
      v = (i % 2 == 0) ? 8'h41 : 8'h40;
      check("wrap_read", 32'(host_rd_data), 32'(prev));
      cpu_out    = v;
      host_rd_en = 1'b1;
      tick();
      check("wrap_count", 32'(out_count), 32'h1);
      prev = v;
    end
    check("wrap_last", 32'(host_rd_data), 32'h40);
    tick();
    host_rd_en = 1'b0;
    check("wrap_empty", 32'(host_empty), 32'h1);
    check("wrap_overflow", 32'(overflow), 32'h0);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
